// File: rtl/dac_update_scheduler.sv
// dac_update_scheduler
//
// Shares one DAC8411 serial writer between N_REQ data requesters. A round-robin
// arbiter picks a requester while idle, the winning code is latched, one
// serializer transaction is started, and after it finishes a minimum idle gap
// is enforced before the next grant. A serializer that never completes is
// abandoned after BUSY_TIMEOUT cycles and flagged on a sticky error output.
//
// Optional feature: define DAC_SCHED_STATS_EN to add per-requester saturating
// 16-bit grant counters on output grant_count.
//
// Ports:
//   clk          IP clock, shared with the ADC/DAC drivers
//   areset       asynchronous, active-high reset
//   enable       allows new grants; an in-flight transaction always finishes
//   req_valid    per-requester data valid, held until accepted
//   req_data     packed codes, requester i at [i*DAC_WIDTH +: DAC_WIDTH]
//   req_ready    accept strobe, one-hot or zero
//   dac_data     latched code to the serializer
//   dac_start    one-cycle start pulse to the serializer
//   dac_busy     serializer busy, high while shifting
//   grant_id     index of the last accepted requester
//   timeout_err  sticky, serializer never completed
//   grant_count  (DAC_SCHED_STATS_EN only) 16-bit grant counter per requester

module dac_update_scheduler #(
    parameter int unsigned N_REQ        = 3,
    parameter int unsigned DAC_WIDTH    = 16,
    parameter int unsigned MIN_GAP      = 4,
    parameter int unsigned BUSY_TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         areset,
    input  logic                         enable,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*DAC_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic [DAC_WIDTH-1:0]         dac_data,
    output logic                         dac_start,
    input  logic                         dac_busy,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic                         timeout_err
`ifdef DAC_SCHED_STATS_EN
    ,
    output logic [N_REQ*16-1:0]          grant_count
`endif
);

    localparam int unsigned ID_W    = $clog2(N_REQ);
    localparam int unsigned CNT_MAX = (BUSY_TIMEOUT > MIN_GAP) ? BUSY_TIMEOUT : MIN_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StGap
    } state_e;

    state_e                 state_q, state_d;
    logic [DAC_WIDTH-1:0]   dac_data_q, dac_data_d;
    logic [ID_W-1:0]        grant_id_q, grant_id_d;
    logic [ID_W-1:0]        last_q, last_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   timeout_err_q, timeout_err_d;

    logic [ID_W-1:0]        winner;
    logic                   found;
    logic                   handshake;
    logic [CNT_W:0]         cnt_inc;

    // Round-robin scan starting just after the last winner.
    always_comb begin
        logic [ID_W-1:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((32'(last_q) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign handshake = (state_q == StIdle) && enable && found;
    assign cnt_inc   = {1'b0, cnt_q} + 1'b1;

    // State register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q       <= StIdle;
            dac_data_q    <= '0;
            grant_id_q    <= '0;
            last_q        <= ID_W'(N_REQ - 1);
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dac_data_q    <= dac_data_d;
            grant_id_q    <= grant_id_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state logic. One counter serves both the busy timeout and the gap,
    // since the two phases never overlap.
    always_comb begin
        state_d       = state_q;
        dac_data_d    = dac_data_q;
        grant_id_d    = grant_id_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            StIdle: begin
                if (handshake) begin
                    dac_data_d = req_data[32'(winner)*DAC_WIDTH +: DAC_WIDTH];
                    grant_id_d = winner;
                    last_d     = winner;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy, StWaitDone: begin
                cnt_d = cnt_inc[CNT_W-1:0];
                // Completion wins over a timeout landing in the same cycle.
                if (state_q == StWaitDone && !dac_busy) begin
                    cnt_d   = '0;
                    state_d = (MIN_GAP == 0) ? StIdle : StGap;
                end else if (32'(cnt_inc) >= BUSY_TIMEOUT) begin
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                    state_d       = StGap;
                end else if (state_q == StWaitBusy && dac_busy) begin
                    state_d = StWaitDone;
                end
            end
            StGap: begin
                // Reached on timeout even with MIN_GAP == 0; then it lasts one cycle.
                if (32'(cnt_inc) >= MIN_GAP) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs. req_ready is gated by areset so all outputs read zero while in reset.
    always_comb begin
        req_ready   = '0;
        if (handshake && !areset) begin
            req_ready[winner] = 1'b1;
        end
        dac_start   = (state_q == StIssue);
        dac_data    = dac_data_q;
        grant_id    = grant_id_q;
        timeout_err = timeout_err_q;
    end

`ifdef DAC_SCHED_STATS_EN
    logic [N_REQ-1:0][15:0] grant_count_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            grant_count_q <= '0;
        end else if (handshake && grant_count_q[winner] != 16'hFFFF) begin
            grant_count_q[winner] <= grant_count_q[winner] + 16'd1;
        end
    end

    assign grant_count = grant_count_q;
`endif

endmodule
